// File: rtl/resource_pkg.sv
// Shared definitions for the resource bank: FSM states, channel indices and defaults.
package resource_pkg;

  typedef enum logic [1:0] {
    RB_IDLE  = 2'd0,
    RB_CHECK = 2'd1,
    RB_DEAD  = 2'd2
  } rb_state_e;

  localparam int CH_FLUID  = 0;
  localparam int CH_ENERGY = 1;
  localparam int CH_TRACER = 2;

  localparam int CAP_FLUID  = 16;
  localparam int CAP_ENERGY = 256;
  localparam int CAP_TRACER = 64;

  localparam int DEF_REFILL_STEP = 4;

endpackage

// File: rtl/resource_channel.sv
// One resource channel: level register, clamped refill, shortfall compare, committed debit.
module resource_channel #(
  parameter int           W           = 9,
  parameter logic [W-1:0] CAP         = '0,
  parameter int           REFILL_STEP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refill_en,
  input  logic         debit_en,
  input  logic [W-1:0] amt,
  output logic         insuf,
  output logic [W-1:0] level,
  output logic         empty
);

  logic [W:0]   sum;
  logic [W-1:0] refill_level;

  // Refill sum is one bit wider than the level so it can never wrap; clamp to capacity.
  always_comb begin
    sum          = {1'b0, level} + (W+1)'(REFILL_STEP);
    refill_level = (sum > {1'b0, CAP}) ? CAP : sum[W-1:0];
  end

  assign insuf = amt > level;
  assign empty = (level == '0);

  // Debit only commits when every channel covered its amount, so it cannot underflow.
  always_ff @(posedge clk) begin
    if (reset)          level <= CAP;
    else if (debit_en)  level <= level - amt;
    else if (refill_en) level <= refill_level;
  end

endmodule

// File: rtl/resource_bank.sv
// N-channel resource store: all-or-nothing debit handshake, per-channel refill, sticky dead state.
module resource_bank
  import resource_pkg::*;
#(
  parameter int               NCH         = 3,
  parameter int               W           = 9,
  parameter logic [NCH*W-1:0] CAPS        = {W'(CAP_TRACER), W'(CAP_ENERGY), W'(CAP_FLUID)},
  parameter int               REFILL_STEP = DEF_REFILL_STEP,
  parameter int               KILL_CH     = CH_ENERGY,
  parameter int               SHOT_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [NCH*W-1:0]   req_amt,
  output logic               req_ready,
  output logic               resp_valid,
  output logic               resp_grant,
  output logic [NCH-1:0]     resp_short,
  input  logic [NCH-1:0]     refill,
  output logic [NCH*W-1:0]   level,
  output logic [NCH-1:0]     empty,
  output logic               dead,
  output logic [SHOT_W-1:0]  shots
);

  rb_state_e               state, state_nx;
  logic [NCH-1:0][W-1:0]   amt_q;
  logic [NCH-1:0][W-1:0]   lvl;
  logic [NCH-1:0]          insuf;
  logic [NCH-1:0]          refill_en;
  logic                    grant_all;
  logic                    latch_en;
  logic                    commit;
  logic                    kill;

  assign grant_all = ~|insuf;

  // The kill channel ends at zero either because the debit drained it exactly
  // (level == amt) or because it was already zero and the request was refused.
  assign kill = grant_all ? (lvl[KILL_CH] == amt_q[KILL_CH]) : (lvl[KILL_CH] == '0);

  // Next-state and per-cycle control for the request handshake.
  always_comb begin
    state_nx = state;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state)
      RB_IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          state_nx = RB_CHECK;
        end
      end
      RB_CHECK: begin
        commit   = grant_all;
        state_nx = kill ? RB_DEAD : RB_IDLE;
      end
      RB_DEAD:  state_nx = RB_DEAD;
      default:  state_nx = RB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RB_IDLE;
    else       state <= state_nx;
  end

  // Amount latch, captured on acceptance and held through CHECK.
  always_ff @(posedge clk) begin
    if (reset)         amt_q <= '0;
    else if (latch_en) amt_q <= req_amt;
  end

  // One-cycle response pulse following CHECK; reset suppresses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_grant <= 1'b0;
      resp_short <= '0;
    end else begin
      resp_valid <= (state == RB_CHECK);
      resp_grant <= commit;
      resp_short <= (state == RB_CHECK) ? insuf : '0;
    end
  end

  // Granted-request counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)       shots <= '0;
    else if (commit) shots <= shots + 1'b1;
  end

  // Refill is only honoured while idle; CHECK and DEAD freeze it.
  assign refill_en = (state == RB_IDLE) ? refill : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    resource_channel #(
      .W           (W),
      .CAP         (CAPS[i*W +: W]),
      .REFILL_STEP (REFILL_STEP)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .refill_en (refill_en[i]),
      .debit_en  (commit),
      .amt       (amt_q[i]),
      .insuf     (insuf[i]),
      .level     (lvl[i]),
      .empty     (empty[i])
    );
  end

  assign level     = lvl;
  assign req_ready = (state == RB_IDLE);
  assign dead      = (state == RB_DEAD);

endmodule

// File: tb/tb_resource_bank.sv
// Randomized and directed checks of resource_bank against a transaction-level model.
module tb_resource_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [26:0] req_amt;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_grant;
  logic [2:0]  resp_short;
  logic [2:0]  refill;
  logic [26:0] level;
  logic [2:0]  empty;
  logic        dead;
  logic [2:0]  shots;

  int nvec = 0;
  int nerr = 0;

  localparam int CAPV [3] = '{16, 256, 64};

  // Transaction-level model state
  int         mlvl [3];
  int         mshots;
  bit         mdead;
  logic       exp_rv, exp_g;
  logic [2:0] exp_s;

  always #5 clk = ~clk;

  resource_bank dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_amt    (req_amt),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_grant (resp_grant),
    .resp_short (resp_short),
    .refill     (refill),
    .level      (level),
    .empty      (empty),
    .dead       (dead),
    .shots      (shots)
  );

  function automatic logic [26:0] pk(input int a0, input int a1, input int a2);
    return {9'(a2), 9'(a1), 9'(a0)};
  endfunction

  function automatic logic [26:0] mpk();
    return pk(mlvl[0], mlvl[1], mlvl[2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mlvl[i] = CAPV[i];
    mshots = 0;
    mdead  = 1'b0;
  endtask

  task automatic model_refill(input logic [2:0] rf);
    if (!mdead)
      for (int i = 0; i < 3; i++)
        if (rf[i]) mlvl[i] = (mlvl[i] + 4 > CAPV[i]) ? CAPV[i] : mlvl[i] + 4;
  endtask

  task automatic model_check(input int a0, input int a1, input int a2);
    int a [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    exp_rv = 1'b0; exp_g = 1'b0; exp_s = 3'b000;
    if (!mdead) begin
      exp_rv = 1'b1;
      for (int i = 0; i < 3; i++) exp_s[i] = (a[i] > mlvl[i]);
      exp_g = (exp_s == 3'b000);
      if (exp_g) begin
        for (int i = 0; i < 3; i++) mlvl[i] -= a[i];
        mshots = (mshots + 1) % 8;
      end
      mdead = (mlvl[1] == 0);
    end
  endtask

  // Present one request (with optional same-cycle refill) and sample the response slot.
  task automatic do_req(input int a0, input int a1, input int a2, input logic [2:0] rf,
                        output logic rv, output logic g, output logic [2:0] s);
    req_valid = 1'b1;
    req_amt   = pk(a0, a1, a2);
    refill    = rf;
    tick();
    model_refill(rf);
    req_valid = 1'b0;
    refill    = 3'b000;
    tick();
    rv = resp_valid; g = resp_grant; s = resp_short;
    model_check(a0, a1, a2);
  endtask

  task automatic idle(input logic [2:0] rf);
    req_valid = 1'b0;
    refill    = rf;
    tick();
    model_refill(rf);
    refill = 3'b000;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    nvec++; if (level !== pk(16, 256, 64)) begin nerr++; $display("FAIL reset_level: got %h want %h", level, pk(16, 256, 64)); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    nvec++; if (dead !== 1'b0) begin nerr++; $display("FAIL reset_dead: got %b want 0", dead); end
    nvec++; if (shots !== 3'd0) begin nerr++; $display("FAIL reset_shots: got %0d want 0", shots); end
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    nvec++; if (empty !== 3'b000) begin nerr++; $display("FAIL reset_empty: got %b want 000", empty); end
  endtask

  task automatic test_grant();
    logic rv, g; logic [2:0] s;
    do_req(1, 2, 0, 3'b000, rv, g, s);
    nvec++; if (rv !== 1'b1 || g !== 1'b1 || s !== 3'b000) begin nerr++; $display("FAIL grant_resp: got v%b g%b s%b want v1 g1 s000", rv, g, s); end
    nvec++; if (level !== pk(15, 254, 64)) begin nerr++; $display("FAIL grant_level: got %h want %h", level, pk(15, 254, 64)); end
    nvec++; if (shots !== 3'd1) begin nerr++; $display("FAIL grant_shots: got %0d want 1", shots); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL grant_ready: got %b want 1", req_ready); end
    idle(3'b000);
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL grant_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_short();
    logic rv, g; logic [2:0] s;
    do_req(16, 1, 0, 3'b000, rv, g, s);
    nvec++; if (rv !== 1'b1 || g !== 1'b0 || s !== 3'b001) begin nerr++; $display("FAIL short_resp: got v%b g%b s%b want v1 g0 s001", rv, g, s); end
    nvec++; if (level !== pk(15, 254, 64)) begin nerr++; $display("FAIL short_level: got %h want %h", level, pk(15, 254, 64)); end
    nvec++; if (shots !== 3'd1) begin nerr++; $display("FAIL short_shots: got %0d want 1", shots); end
    do_req(0, 0, 65, 3'b000, rv, g, s);
    nvec++; if (g !== 1'b0 || s !== 3'b100) begin nerr++; $display("FAIL short_over_cap: got g%b s%b want g0 s100", g, s); end
  endtask

  task automatic test_refill();
    logic rv, g; logic [2:0] s;
    int exp_f [4];
    exp_f = '{7, 11, 15, 16};
    do_req(12, 0, 0, 3'b000, rv, g, s);
    nvec++; if (level !== pk(3, 254, 64)) begin nerr++; $display("FAIL refill_setup: got %h want %h", level, pk(3, 254, 64)); end
    for (int k = 0; k < 4; k++) begin
      idle(3'b001);
      nvec++; if (level !== pk(exp_f[k], 254, 64)) begin nerr++; $display("FAIL refill_step%0d: got %h want %h", k, level, pk(exp_f[k], 254, 64)); end
    end
    do_req(13, 0, 0, 3'b000, rv, g, s);
    do_req(7, 0, 0, 3'b001, rv, g, s);
    nvec++; if (g !== 1'b1 || s !== 3'b000) begin nerr++; $display("FAIL refill_req_same_cycle: got g%b s%b want g1 s000", g, s); end
    nvec++; if (level !== pk(0, 254, 64) || empty !== 3'b001) begin nerr++; $display("FAIL refill_req_level: got %h e%b want %h e001", level, empty, pk(0, 254, 64)); end
  endtask

  task automatic test_random();
    logic rv, g; logic [2:0] s;
    int a0, a1, a2, e;
    logic [2:0] rf;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rf = 3'($urandom);
        idle(rf);
        nvec++; if (level !== mpk()) begin nerr++; $display("FAIL rand_idle_level[%0d]: got %h want %h", n, level, mpk()); end
      end else begin
        rf = 3'($urandom);
        a0 = $urandom_range(0, 20);
        a1 = $urandom_range(0, 40);
        a2 = $urandom_range(0, 70);
        e  = (rf[1] && mlvl[1] + 4 <= CAPV[1]) ? mlvl[1] + 4 : (rf[1] ? CAPV[1] : mlvl[1]);
        if (a1 == e) a1 = a1 + 1;
        do_req(a0, a1, a2, rf, rv, g, s);
        nvec++; if (rv !== exp_rv || g !== exp_g || s !== exp_s) begin nerr++; $display("FAIL rand_resp[%0d]: got v%b g%b s%b want v%b g%b s%b", n, rv, g, s, exp_rv, exp_g, exp_s); end
        nvec++; if (level !== mpk()) begin nerr++; $display("FAIL rand_level[%0d]: got %h want %h", n, level, mpk()); end
        nvec++; if (shots !== 3'(mshots) || dead !== mdead) begin nerr++; $display("FAIL rand_shots_dead[%0d]: got %0d/%b want %0d/%b", n, shots, dead, mshots, mdead); end
      end
    end
  endtask

  task automatic test_kill();
    logic rv, g; logic [2:0] s;
    apply_reset();
    do_req(0, 254, 0, 3'b000, rv, g, s);
    nvec++; if (level !== pk(16, 2, 64) || dead !== 1'b0) begin nerr++; $display("FAIL kill_setup: got %h d%b want %h d0", level, dead, pk(16, 2, 64)); end
    do_req(0, 2, 0, 3'b000, rv, g, s);
    nvec++; if (rv !== 1'b1 || g !== 1'b1) begin nerr++; $display("FAIL kill_resp: got v%b g%b want v1 g1", rv, g); end
    nvec++; if (level !== pk(16, 0, 64) || empty !== 3'b010) begin nerr++; $display("FAIL kill_level: got %h e%b want %h e010", level, empty, pk(16, 0, 64)); end
    nvec++; if (dead !== 1'b1 || req_ready !== 1'b0) begin nerr++; $display("FAIL kill_state: got d%b r%b want d1 r0", dead, req_ready); end
    do_req(1, 0, 0, 3'b111, rv, g, s);
    nvec++; if (rv !== 1'b0) begin nerr++; $display("FAIL dead_no_resp: got %b want 0", rv); end
    idle(3'b111);
    idle(3'b111);
    nvec++; if (level !== pk(16, 0, 64) || dead !== 1'b1) begin nerr++; $display("FAIL dead_frozen: got %h d%b want %h d1", level, dead, pk(16, 0, 64)); end
    apply_reset();
    nvec++; if (level !== pk(16, 256, 64) || dead !== 1'b0 || req_ready !== 1'b1) begin nerr++; $display("FAIL dead_reset: got %h d%b r%b want %h d0 r1", level, dead, req_ready, pk(16, 256, 64)); end
  endtask

  task automatic test_reset_mid_check();
    logic rv, g; logic [2:0] s;
    do_req(0, 0, 0, 3'b000, rv, g, s);
    req_valid = 1'b1;
    req_amt   = pk(1, 1, 1);
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL midcheck_resp: got %b want 0", resp_valid); end
    nvec++; if (shots !== 3'd0 || level !== pk(16, 256, 64)) begin nerr++; $display("FAIL midcheck_state: got s%0d %h want s0 %h", shots, level, pk(16, 256, 64)); end
    idle(3'b000);
    nvec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin nerr++; $display("FAIL midcheck_after: got v%b r%b want v0 r1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    logic rv, g; logic [2:0] s;
    for (int k = 1; k <= 8; k++) begin
      do_req(0, 0, 0, 3'b000, rv, g, s);
      nvec++; if (g !== 1'b1 || shots !== 3'(k % 8)) begin nerr++; $display("FAIL wrap[%0d]: got g%b s%0d want g1 s%0d", k, g, shots, k % 8); end
    end
    nvec++; if (level !== pk(16, 256, 64)) begin nerr++; $display("FAIL wrap_level: got %h want %h", level, pk(16, 256, 64)); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_amt   = '0;
    refill    = 3'b000;
    model_reset();
    test_reset();
    test_grant();
    test_short();
    test_refill();
    test_random();
    test_kill();
    test_reset_mid_check();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
